spi_regfile_rw: RTL



---
 rtl/spi_regfile_rw.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/spi_regfile_rw.sv
`default_nettype none
// ============================================================================
// spi_regfile_rw : SPI mode-0 register file with read/write, oversampled in clk.
// Optional macro SPI_READBACK_EN drives read data on CIPO.   Rev 1.0
// ============================================================================
module spi_regfile_rw #(
    parameter int                 NUM_REGS  = 5,
    parameter int                 ADDR_W    = 7,
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int C_FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W       = $clog2(C_FRAME_LEN + 1);
    localparam int SH_W        = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0] C_CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(C_FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] C_FULL      = CNT_W'(C_FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CMD      = 2'd1,
        S_DATA     = 2'd2,
        S_WAIT_END = 2'd3
    } state_t;

    logic [1:0]        r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic              r_sclk_d, r_ncs_d;
    logic              w_sclk_rise, w_cs_rise, w_cs_fall, w_copi;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SH_W-1:0]   r_shift, w_shift_nxt;
    logic              r_cmd, r_overrun, w_addr_ok;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_copi_sync <= 2'b00;
            r_ncs_sync  <= 2'b11;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], SCLK};
            r_copi_sync <= {r_copi_sync[0], COPI};
            r_ncs_sync  <= {r_ncs_sync[0], nCS};
            r_sclk_d    <= r_sclk_sync[1];
            r_ncs_d     <= r_ncs_sync[1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_cs_rise   = r_ncs_sync[1] & ~r_ncs_d;
    assign w_cs_fall   = ~r_ncs_sync[1] & r_ncs_d;
    assign w_copi      = r_copi_sync[1];
    assign w_shift_nxt = {r_shift[SH_W-2:0], w_copi};
    assign w_addr_ok   = int'(r_addr) < NUM_REGS;

    // cs_rise is tested first so a coincident SCLK edge is never sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_cmd     <= 1'b0;
            r_addr    <= '0;
            r_overrun <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (w_cs_rise) begin
                if (r_state != S_IDLE) begin
                    if (r_cnt == C_FULL && !r_overrun) begin
                        if (r_cmd && w_addr_ok) begin
                            r_regs[r_addr[IDX_W-1:0]] <= r_shift[DATA_W-1:0];
                            wr_strobe <= 1'b1;
                            wr_addr   <= r_addr;
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                r_state <= S_IDLE;
            end else if (w_cs_fall) begin
                r_state   <= S_CMD;
                r_cnt     <= '0;
                r_shift   <= '0;
                r_overrun <= 1'b0;
            end else if (w_sclk_rise) begin
                case (r_state)
                    S_CMD: begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == C_CMD_LAST) begin
                            r_cmd   <= w_shift_nxt[ADDR_W];
                            r_addr  <= w_shift_nxt[ADDR_W-1:0];
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == C_DATA_LAST) r_state <= S_WAIT_END;
                    end
                    S_WAIT_END: r_overrun <= 1'b1;
                    default:    r_state   <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

`ifdef SPI_READBACK_EN
    logic              w_sclk_fall, w_cmd_done, w_rd_hit;
    logic [DATA_W-1:0] r_tx, w_tx_load;
    logic              r_cipo;

    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
    assign w_cmd_done  = (r_state == S_CMD) && w_sclk_rise && !w_cs_rise && !w_cs_fall
                         && (r_cnt == C_CMD_LAST);
    assign w_rd_hit    = !w_shift_nxt[ADDR_W] && (int'(w_shift_nxt[ADDR_W-1:0]) < NUM_REGS);
    assign w_tx_load   = w_rd_hit ? r_regs[w_shift_nxt[IDX_W-1:0]] : '0;

    // Data bit presented on each fall in DATA so the controller samples it on the next rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (w_cs_rise || w_cs_fall) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (w_cmd_done) begin
            r_tx   <= w_tx_load;
        end else if (w_sclk_fall) begin
            if (r_state == S_DATA) begin
                r_cipo <= r_tx[DATA_W-1];
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
            end else begin
                r_cipo <= 1'b0;
            end
        end
    end

    assign CIPO = r_cipo;
`else
    assign CIPO = 1'b0;
`endif

endmodule
`default_nettype wire
